// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver with one-entry holding register
module sipo_deserializer #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         ser_en,
    input  logic         ser_in,
    input  logic         dir,
    input  logic         out_ready,
    output logic [N-1:0] OUT,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic [N-1:0]   out_q, out_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic [N-1:0]   shifted;
    logic           last_bit;
    logic           slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        shifted   = dir_q ? {ser_in, shreg_q[N-1:1]} : {shreg_q[N-2:0], ser_in};
        last_bit  = (cnt_q == CW'(N - 1));
        // A word consumed in the same cycle frees the slot for a completing word.
        slot_free = !valid_q || out_ready;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    dir_d   = dir;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ser_en) begin
                    shreg_d = shifted;
                    if (last_bit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (slot_free) begin
                            out_d   = shifted;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign OUT       = out_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized and directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         ser_en = 1'b0;
    logic         ser_in = 1'b0;
    logic         dir = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] OUT;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // seq[i] is the i-th serial bit on the wire
    localparam logic [N-1:0] SEQ_B2 = 8'h4D;
    localparam logic [N-1:0] SEQ_0F = 8'hF0;

    sipo_deserializer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ser_en(ser_en),
        .ser_in(ser_in), .dir(dir), .out_ready(out_ready), .OUT(OUT),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // First bit lands in the MSB when shifting left, in the LSB when shifting right.
    function automatic logic [N-1:0] exp_word(input logic [N-1:0] seq, input logic d);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (d) w[i] = seq[i];
            else   w[N-1-i] = seq[i];
        end
        return w;
    endfunction

    task automatic send_frame(input logic [N-1:0] seq, input logic d, input bit gap,
                              input bit toggle, input bit ready_last);
        logic save;
        start = 1'b1;
        dir   = d;
        cyc();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (toggle) dir = ~dir;
            if (gap && i != 0) begin
                ser_en = 1'b0;
                cyc();
            end
            ser_en = 1'b1;
            ser_in = seq[i];
            save   = out_ready;
            if (ready_last && i == N - 1) out_ready = 1'b1;
            cyc();
            out_ready = save;
            ser_en    = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (OUT !== '0)       begin errors++; $display("FAIL reset_out got=%h exp=00", OUT); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_msb_first;
        out_ready = 1'b0;
        send_frame(SEQ_B2, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (OUT !== 8'hB2)      begin errors++; $display("FAIL msb_out got=%h exp=b2", OUT); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got=%b exp=1", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL msb_busy got=%b exp=0", busy); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL msb_consume_valid got=%b exp=0", out_valid); end
        checks++; if (OUT !== 8'hB2)      begin errors++; $display("FAIL msb_consume_out got=%h exp=b2", OUT); end
    endtask

    task automatic test_lsb_first;
        out_ready = 1'b1;
        send_frame(SEQ_B2, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (OUT !== 8'h4D) begin errors++; $display("FAIL lsb_out got=%h exp=4d", OUT); end
        send_frame(SEQ_B2, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (OUT !== 8'h4D) begin errors++; $display("FAIL lsb_dir_toggle_out got=%h exp=4d", OUT); end
        cyc();
    endtask

    task automatic test_gapped;
        logic [N-1:0] w;
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst = 1'b1; cyc(); rst = 1'b0;
            start = 1'b1; dir = d[0]; cyc(); start = 1'b0;
            for (int i = 0; i < N; i++) begin
                ser_en = 1'b1; ser_in = SEQ_B2[i]; cyc();
                ser_en = 1'b0;
                if (i != N - 1) begin
                    cyc();
                    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL gap_busy d=%0d bit=%0d got=%b exp=1", d, i, busy); end
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid d=%0d bit=%0d got=%b exp=0", d, i, out_valid); end
                end
            end
            w = (d == 0) ? 8'hB2 : 8'h4D;
            checks++; if (OUT !== w)          begin errors++; $display("FAIL gap_out d=%0d got=%h exp=%h", d, OUT, w); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid d=%0d got=%b exp=1", d, out_valid); end
            checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL gap_done_busy d=%0d got=%b exp=0", d, busy); end
        end
    endtask

    task automatic test_overrun;
        logic [N-1:0] seq_b;
        seq_b = 8'h3C;
        rst = 1'b1; cyc(); rst = 1'b0;
        out_ready = 1'b0;
        send_frame(SEQ_B2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        send_frame(seq_b, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (OUT !== 8'hB2)      begin errors++; $display("FAIL ovr_drop_out got=%h exp=b2", OUT); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_drop_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL ovr_drop_flag got=%b exp=1", overrun); end
        cyc();
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end

        rst = 1'b1; cyc(); rst = 1'b0;
        send_frame(SEQ_B2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        send_frame(seq_b, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (OUT !== exp_word(seq_b, 1'b0)) begin errors++; $display("FAIL ovr_drain_out got=%h exp=%h", OUT, exp_word(seq_b, 1'b0)); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_drain_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL ovr_drain_flag got=%b exp=0", overrun); end
        out_ready = 1'b1; cyc();
    endtask

    task automatic test_abort;
        logic [N-1:0] prev;
        out_ready = 1'b1;
        start = 1'b1; dir = 1'b0; cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ser_en = 1'b1; ser_in = 1'b1; cyc();
        end
        abort = 1'b1; cyc(); abort = 1'b0; ser_en = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        send_frame(SEQ_0F, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (OUT !== 8'h0F)      begin errors++; $display("FAIL abort_next_out got=%h exp=0f", OUT); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL abort_overrun got=%b exp=0", overrun); end
        cyc();
        prev = OUT;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            ser_en = 1'b1; ser_in = 1'b1;
            if (i == N - 1) abort = 1'b1;
            cyc();
        end
        abort = 1'b0; ser_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_last_valid got=%b exp=0", out_valid); end
        checks++; if (OUT !== prev)       begin errors++; $display("FAIL abort_last_out got=%h exp=%h", OUT, prev); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_last_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] seq;
        seq = 8'hA6;
        out_ready = 1'b1;
        start = 1'b1; dir = 1'b0; cyc(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            ser_en = 1'b1; ser_in = seq[i];
            if (i == 3) begin start = 1'b1; dir = 1'b1; end
            cyc();
            start = 1'b0;
        end
        ser_en = 1'b0;
        checks++; if (OUT !== exp_word(seq, 1'b0)) begin errors++; $display("FAIL start_in_shift_out got=%h exp=%h", OUT, exp_word(seq, 1'b0)); end

        out_ready = 1'b0;
        cyc();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_en = 1'b1; ser_in = 1'b1; cyc();
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if (OUT !== '0)         begin errors++; $display("FAIL midrst_out got=%h exp=00", OUT); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
        cyc(); cyc();
        ser_en = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ser_en_busy got=%b exp=0", busy); end
    endtask

    typedef struct {
        logic st;
        logic en;
        logic bi;
        logic dr;
        logic rdy;
        logic last;
        logic bsy;
        logic [N-1:0] word;
    } stim_t;

    task automatic test_random;
        stim_t q[$];
        stim_t s;
        logic [N-1:0] seq;
        logic d;
        logic [N-1:0] m_out;
        logic m_valid, m_overrun;
        int gaps;

        for (int f = 0; f < 30; f++) begin
            seq = N'($urandom);
            d   = 1'($urandom);
            s = '{st: 1'b1, en: 1'($urandom), bi: 1'($urandom), dr: d, rdy: 1'($urandom),
                  last: 1'b0, bsy: 1'b1, word: '0};
            q.push_back(s);
            for (int i = 0; i < N; i++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    s = '{st: 1'($urandom), en: 1'b0, bi: 1'($urandom), dr: 1'($urandom),
                          rdy: 1'($urandom), last: 1'b0, bsy: 1'b1, word: '0};
                    q.push_back(s);
                end
                s = '{st: 1'b0, en: 1'b1, bi: seq[i], dr: 1'($urandom), rdy: 1'($urandom),
                      last: (i == N - 1), bsy: (i != N - 1), word: exp_word(seq, d)};
                q.push_back(s);
            end
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                s = '{st: 1'b0, en: 1'($urandom), bi: 1'($urandom), dr: 1'($urandom),
                      rdy: 1'($urandom), last: 1'b0, bsy: 1'b0, word: '0};
                q.push_back(s);
            end
        end

        rst = 1'b1; cyc(); rst = 1'b0;
        m_out = '0; m_valid = 1'b0; m_overrun = 1'b0;
        foreach (q[k]) begin
            start = q[k].st; ser_en = q[k].en; ser_in = q[k].bi;
            dir = q[k].dr; out_ready = q[k].rdy;
            if (q[k].last) begin
                if (!m_valid || q[k].rdy) begin
                    m_out = q[k].word;
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_valid && q[k].rdy) begin
                m_valid = 1'b0;
            end
            cyc();
            checks++; if (OUT !== m_out)         begin errors++; $display("FAIL rnd_out step=%0d got=%h exp=%h", k, OUT, m_out); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid step=%0d got=%b exp=%b", k, out_valid, m_valid); end
            checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL rnd_overrun step=%0d got=%b exp=%b", k, overrun, m_overrun); end
            checks++; if (busy !== q[k].bsy)     begin errors++; $display("FAIL rnd_busy step=%0d got=%b exp=%b", k, busy, q[k].bsy); end
        end
        start = 1'b0; ser_en = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        cyc();
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gapped();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
